// File: rtl/vic_regs.sv
// VIC-I register file ($9000-$900F): chip registers, CPU readback,
// raster line counter and decoded video/audio controls.
module vic_regs #(
    parameter int         LINES     = 312,
    parameter logic [7:0] REG0_INIT = 8'h0C,
    parameter logic [7:0] REG1_INIT = 8'h26,
    parameter logic [7:0] REG2_INIT = 8'h96,
    parameter logic [7:0] REG3_INIT = 8'h2E,
    parameter logic [7:0] REG5_INIT = 8'hF0,
    parameter logic [7:0] REGF_INIT = 8'h1B
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_i,
    input  logic [3:0]  rs_i,
    input  logic        wr_i,
    input  logic        rd_i,
    input  logic [7:0]  din_i,
    output logic [7:0]  dout_o,
    input  logic        line_tick_i,
    input  logic        frame_tick_i,
    output logic [8:0]  raster_o,
    output logic [15:0] screen_addr_o,
    output logic [15:0] char_rom_addr_o,
    output logic [15:0] color_ram_addr_o,
    output logic [6:0]  x_origin_o,
    output logic        interlace_o,
    output logic [7:0]  y_origin_o,
    output logic [6:0]  columns_o,
    output logic [5:0]  rows_o,
    output logic        double_height_o,
    output logic [7:0]  voice0_o,
    output logic [7:0]  voice1_o,
    output logic [7:0]  voice2_o,
    output logic [7:0]  noise_o,
    output logic [3:0]  volume_o,
    output logic [3:0]  aux_color_o,
    output logic [2:0]  border_color_o,
    output logic        inverted_o,
    output logic [3:0]  back_color_o
);

    logic [7:0] regs_q [16];
    logic [8:0] raster_q, raster_d;
    logic [7:0] dout_q;
    logic [7:0] rdata;
    logic       wr_en;

    // Regs 4 and 6-9 are read-only views (raster high bits, light pen, paddles)
    assign wr_en = cs_i & wr_i & (rs_i != 4'h4) & !(rs_i >= 4'h6 && rs_i <= 4'h9);

    // Readback mux; uses current (pre-write, pre-tick) state
    always_comb begin
        rdata = regs_q[rs_i];
        unique case (rs_i)
            4'h3:        rdata = {raster_q[0], regs_q[3][6:0]};
            4'h4:        rdata = raster_q[8:1];
            4'h6, 4'h7:  rdata = 8'h00;
            4'h8, 4'h9:  rdata = 8'hFF;
            default:     rdata = regs_q[rs_i];
        endcase
    end

    // Raster next state: frame_tick wins over line_tick, wrap at LINES-1
    always_comb begin
        raster_d = raster_q;
        if (frame_tick_i)
            raster_d = 9'd0;
        else if (line_tick_i)
            raster_d = (raster_q == 9'(LINES - 1)) ? 9'd0 : raster_q + 9'd1;
    end

    // Register storage, raster counter and registered readback
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
            regs_q[0]  <= REG0_INIT;
            regs_q[1]  <= REG1_INIT;
            regs_q[2]  <= REG2_INIT;
            regs_q[3]  <= {1'b0, REG3_INIT[6:0]};
            regs_q[5]  <= REG5_INIT;
            regs_q[15] <= REGF_INIT;
            raster_q   <= 9'd0;
            dout_q     <= 8'h00;
        end else begin
            if (wr_en)
                regs_q[rs_i] <= (rs_i == 4'h3) ? {1'b0, din_i[6:0]} : din_i;
            if (cs_i && rd_i)
                dout_q <= rdata;
            raster_q <= raster_d;
        end
    end

    assign dout_o   = dout_q;
    assign raster_o = raster_q;

    assign char_rom_addr_o  = {~regs_q[5][3], 2'b00, regs_q[5][2:0], 10'b0};
    assign screen_addr_o    = {~regs_q[5][7], 2'b00, regs_q[5][6:4], regs_q[2][7], 9'b0};
    assign color_ram_addr_o = 16'h9400 | {6'b0, regs_q[2][7], 9'b0};

    assign x_origin_o      = regs_q[0][6:0];
    assign interlace_o     = regs_q[0][7];
    assign y_origin_o      = regs_q[1];
    assign columns_o       = regs_q[2][6:0];
    assign rows_o          = regs_q[3][6:1];
    assign double_height_o = regs_q[3][0];
    assign voice0_o        = regs_q[10];
    assign voice1_o        = regs_q[11];
    assign voice2_o        = regs_q[12];
    assign noise_o         = regs_q[13];
    assign volume_o        = regs_q[14][3:0];
    assign aux_color_o     = regs_q[14][7:4];
    assign border_color_o  = regs_q[15][2:0];
    assign inverted_o      = regs_q[15][3];
    assign back_color_o    = regs_q[15][7:4];

endmodule

// File: tb/tb_vic_regs.sv
// Self-checking bench for vic_regs: directed scenarios plus randomized traffic
// checked against a behavioural model of the register file and raster.
module tb_vic_regs;
    localparam int LINES = 312;

    logic clk = 0;
    logic reset, cs, wr, rd, line_tick, frame_tick;
    logic [3:0] rs;
    logic [7:0] din, dout;
    logic [8:0] raster;
    logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
    logic [6:0] x_origin, columns;
    logic interlace, double_height, inverted;
    logic [7:0] y_origin, voice0, voice1, voice2, noise;
    logic [5:0] rows;
    logic [3:0] volume, aux_color, back_color;
    logic [2:0] border_color;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int unsigned mreg [16];
    int unsigned mraster;
    int unsigned mdout;

    always #20 clk = ~clk;

    vic_regs #(.LINES(LINES)) dut (
        .clk_i(clk), .reset_i(reset), .cs_i(cs), .rs_i(rs), .wr_i(wr), .rd_i(rd),
        .din_i(din), .dout_o(dout), .line_tick_i(line_tick), .frame_tick_i(frame_tick),
        .raster_o(raster), .screen_addr_o(screen_addr), .char_rom_addr_o(char_rom_addr),
        .color_ram_addr_o(color_ram_addr), .x_origin_o(x_origin), .interlace_o(interlace),
        .y_origin_o(y_origin), .columns_o(columns), .rows_o(rows),
        .double_height_o(double_height), .voice0_o(voice0), .voice1_o(voice1),
        .voice2_o(voice2), .noise_o(noise), .volume_o(volume), .aux_color_o(aux_color),
        .border_color_o(border_color), .inverted_o(inverted), .back_color_o(back_color)
    );

    function automatic int unsigned m_read(int unsigned a);
        case (a)
            3:       return ((mraster % 2) * 128) + (mreg[3] % 128);
            4:       return mraster / 2;
            6, 7:    return 0;
            8, 9:    return 255;
            default: return mreg[a];
        endcase
    endfunction

    // Drive one bus cycle, advance the model, then wait past the edge
    task automatic cyc(input bit c, input int unsigned a, input bit w, input bit r,
                       input int unsigned d, input bit lt, input bit ft, input bit rst);
        int unsigned rb;
        cs = c; rs = 4'(a); wr = w; rd = r; din = 8'(d);
        line_tick = lt; frame_tick = ft; reset = rst;
        if (rst) begin
            for (int i = 0; i < 16; i++) mreg[i] = 0;
            mreg[0] = 'h0C; mreg[1] = 'h26; mreg[2] = 'h96; mreg[3] = 'h2E;
            mreg[5] = 'hF0; mreg[15] = 'h1B;
            mraster = 0; mdout = 0;
        end else begin
            rb = m_read(a);
            if (c && w && a != 4 && !(a >= 6 && a <= 9))
                mreg[a] = (a == 3) ? d % 128 : d;
            if (c && r) mdout = rb;
            if (ft) mraster = 0;
            else if (lt) mraster = (mraster + 1) % LINES;
        end
        @(posedge clk); #1;
        cs = 0; wr = 0; rd = 0; line_tick = 0; frame_tick = 0; reset = 0;
    endtask

    function automatic int unsigned m_char();
        return (((mreg[5] / 8) % 2) ? 0 : 'h8000) + (mreg[5] % 8) * 1024;
    endfunction
    function automatic int unsigned m_screen();
        return ((mreg[5] / 128) ? 0 : 'h8000) + ((mreg[5] / 16) % 8) * 1024
               + (mreg[2] / 128) * 512;
    endfunction

    task automatic test_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (screen_addr !== 16'h1E00) begin n_err++; $display("FAIL reset_screen got %h want 1e00", screen_addr); end
        n_cmp++; if (char_rom_addr !== 16'h8000) begin n_err++; $display("FAIL reset_char got %h want 8000", char_rom_addr); end
        n_cmp++; if (color_ram_addr !== 16'h9600) begin n_err++; $display("FAIL reset_color got %h want 9600", color_ram_addr); end
        n_cmp++; if ({back_color, inverted, border_color} !== 8'h1B) begin n_err++; $display("FAIL reset_colours got %h want 1b", {back_color, inverted, border_color}); end
        n_cmp++; if (raster !== 9'd0 || dout !== 8'h00) begin n_err++; $display("FAIL reset_raster_dout got %0d/%h want 0/00", raster, dout); end
        n_cmp++; if ({interlace, x_origin} !== 8'h0C || y_origin !== 8'h26 || rows !== 6'h17 || double_height !== 1'b0)
            begin n_err++; $display("FAIL reset_geom got %h %h %h %b", {interlace, x_origin}, y_origin, rows, double_height); end
    endtask

    task automatic test_decode();
        cyc(1, 5, 1, 0, 'hCC, 0, 0, 0);
        cyc(1, 2, 1, 0, 'h16, 0, 0, 0);
        n_cmp++; if (char_rom_addr !== 16'h1000) begin n_err++; $display("FAIL decode_char got %h want 1000", char_rom_addr); end
        n_cmp++; if (screen_addr !== 16'h1000) begin n_err++; $display("FAIL decode_screen got %h want 1000", screen_addr); end
        n_cmp++; if (color_ram_addr !== 16'h9400) begin n_err++; $display("FAIL decode_color got %h want 9400", color_ram_addr); end
        n_cmp++; if (columns !== 7'h16) begin n_err++; $display("FAIL decode_columns got %h want 16", columns); end
    endtask

    task automatic test_raster();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 301; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (raster !== 9'h12D) begin n_err++; $display("FAIL raster_301 got %0d want 301", raster); end
        cyc(1, 4, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (dout !== 8'h96) begin n_err++; $display("FAIL read_rs4 got %h want 96", dout); end
        cyc(1, 3, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (dout !== 8'hAE) begin n_err++; $display("FAIL read_rs3 got %h want ae", dout); end
        // read in a tick cycle sees the pre-tick raster
        cyc(1, 3, 0, 1, 0, 1, 0, 0);
        n_cmp++; if (dout !== 8'hAE || raster !== 9'd302) begin n_err++; $display("FAIL read_with_tick got %h/%0d want ae/302", dout, raster); end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < LINES - 1; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (raster !== 9'(LINES - 1)) begin n_err++; $display("FAIL wrap_top got %0d want %0d", raster, LINES - 1); end
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (raster !== 9'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", raster); end
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        n_cmp++; if (raster !== 9'd0) begin n_err++; $display("FAIL frame_wins got %0d want 0", raster); end
    endtask

    task automatic test_special_reads();
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 4, 1, 0, 'h55, 0, 0, 0);
        cyc(1, 4, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (dout !== 8'd4) begin n_err++; $display("FAIL rs4_readonly got %h want 04", dout); end
        cyc(1, 8, 1, 1, 'h12, 0, 0, 0);
        n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL paddle got %h want ff", dout); end
        cyc(1, 6, 1, 1, 'h34, 0, 0, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL lightpen got %h want 00", dout); end
    endtask

    task automatic test_back_to_back();
        cyc(1, 'hA, 1, 1, 'hF0, 0, 0, 0);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL wr_rd_old got %h want 00", dout); end
        cyc(1, 'hA, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (dout !== 8'hF0 || voice0 !== 8'hF0) begin n_err++; $display("FAIL wr_rd_new got %h/%h want f0", dout, voice0); end
        cyc(1, 3, 1, 0, 'hFF, 0, 0, 0);
        n_cmp++; if (rows !== 6'h3F || double_height !== 1'b1) begin n_err++; $display("FAIL reg3_write got %h/%b want 3f/1", rows, double_height); end
    endtask

    task automatic test_reset_wr();
        cyc(1, 'hF, 1, 0, 'h00, 0, 0, 0);
        cyc(1, 'hF, 1, 0, 'h00, 1, 0, 1);
        n_cmp++; if ({back_color, inverted, border_color} !== 8'h1B) begin n_err++; $display("FAIL reset_over_wr got %h want 1b", {back_color, inverted, border_color}); end
        cyc(1, 'hF, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (dout !== 8'h1B || raster !== 9'd0) begin n_err++; $display("FAIL reset_over_wr_read got %h/%0d want 1b/0", dout, raster); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 8) != 0, $urandom % 16, $urandom % 2, $urandom % 2, $urandom % 256,
                ($urandom % 3) == 0, ($urandom % 500) == 0, ($urandom % 700) == 0);
            n_cmp++; if (dout !== 8'(mdout) || raster !== 9'(mraster))
                begin n_err++; $display("FAIL rnd_dout_raster got %h/%0d want %h/%0d", dout, raster, 8'(mdout), mraster); end
            n_cmp++; if (char_rom_addr !== 16'(m_char()) || screen_addr !== 16'(m_screen())
                         || color_ram_addr !== 16'('h9400 + (mreg[2] / 128) * 512))
                begin n_err++; $display("FAIL rnd_addr got %h %h %h", char_rom_addr, screen_addr, color_ram_addr); end
            n_cmp++; if ({voice0, voice1, voice2, noise} !== {8'(mreg[10]), 8'(mreg[11]), 8'(mreg[12]), 8'(mreg[13])}
                         || {aux_color, volume} !== 8'(mreg[14]) || {back_color, inverted, border_color} !== 8'(mreg[15])
                         || {interlace, x_origin} !== 8'(mreg[0]) || y_origin !== 8'(mreg[1])
                         || {rows, double_height} !== 7'(mreg[3]) || columns !== 7'(mreg[2]))
                begin n_err++; $display("FAIL rnd_regs at iter %0d", n); end
        end
    endtask

    initial begin
        cs = 0; rs = 0; wr = 0; rd = 0; din = 0; line_tick = 0; frame_tick = 0; reset = 1;
        test_reset();
        test_decode();
        test_raster();
        test_wrap();
        test_special_reads();
        test_back_to_back();
        test_reset_wr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vic_regs.md
Name: vic_regs

Overview:
VIC-I register file for $9000-$900F. It sits between the CPU bus decode and the video/audio stages. It holds the chip registers and returns readback data to the CPU data-in mux. It also maintains the raster line counter that the kernal and games poll, and presents decoded screen, character and colour base addresses, colours and sound controls to the video and audio blocks.

Parameters:
LINES, 312, scanlines per frame; raster counter wraps at LINES-1 (PAL 312, NTSC 261)
REG0_INIT, 8'h0C, reset value of reg 0 (X origin / interlace)
REG1_INIT, 8'h26, reset value of reg 1 (Y origin)
REG2_INIT, 8'h96, reset value of reg 2 (columns / screen addr bit 9)
REG3_INIT, 8'h2E, reset value of reg 3 bits 6:0 (rows / double height)
REG5_INIT, 8'hF0, reset value of reg 5 (screen/char base)
REGF_INIT, 8'h1B, reset value of reg F (colours)

Ports:
clk  in  1  system clock (25MHz)
reset  in  1  synchronous, active-high
cs  in  1  address[15:4]==12'h900, qualified by the bus cycle
rs  in  4  register select = address[3:0]
wr  in  1  single-cycle write strobe, valid only with cs
rd  in  1  single-cycle read strobe, valid only with cs
din  in  8  CPU write data
dout  out  8  readback data, registered
line_tick  in  1  one-cycle pulse from video at start of each scanline
frame_tick  in  1  one-cycle pulse from video at start of line 0
raster  out  9  current raster line
screen_addr  out  16  CPU address of screen matrix
char_rom_addr  out  16  CPU address of character generator
color_ram_addr  out  16  colour RAM base
x_origin  out  7  reg0[6:0]
interlace  out  1  reg0[7]
y_origin  out  8  reg1
columns  out  7  reg2[6:0]
rows  out  6  reg3[6:1]
double_height  out  1  reg3[0]
voice0, voice1, voice2, noise  out  8 each  regs A-D
volume  out  4  regE[3:0]
aux_color  out  4  regE[7:4]
border_color  out  3  regF[2:0]
inverted  out  1  regF[3]
back_color  out  4  regF[7:4]

Behaviour:
- Storage: 16 x 8 registers. On reset, regs 0,1,2,3,5,F take their INIT parameters; all others reset to 0. Raster resets to 0 and dout resets to 0.
- Write: when cs & wr, reg[rs] <= din at the next edge.
  - Reg 3 stores din[6:0] only; bit 7 is not writable.
  - Reg 4 writes are ignored.
  - Regs 6-9 writes are ignored.
- Read: when cs & rd, dout <= the readback value at the next edge (1-cycle latency). Otherwise dout holds its value.
  - rs=3: {raster[0], reg3[6:0]}
  - rs=4: raster[8:1]
  - rs=6,7 (light pen): 8'h00
  - rs=8,9 (paddles): 8'hFF
  - All other rs: the stored register.
- Write and read in the same cycle: dout returns the old value. The new value is visible on the next read.
- Raster counter (9 bits):
  - frame_tick sets it to 0.
  - Else line_tick increments it; LINES-1 wraps to 0.
  - frame_tick and line_tick in the same cycle: frame_tick wins, result 0.
  - A read in the same cycle as a tick returns the pre-tick raster.
- Address decode (combinational from regs):
  - char_rom_addr = {~reg5[3], 2'b00, reg5[2:0], 10'b0}
  - screen_addr = {~reg5[7], 2'b00, reg5[6:4], reg2[7], 9'b0}
  - color_ram_addr = 16'h9400 | {reg2[7], 9'b0}
- All other outputs are direct combinational slices of the registers as listed under Ports.
- Reset mid-frame: raster returns to 0 and counts from the next line_tick. Reset dominates wr in the same cycle.

Test Plan:
- Reset, no writes -> screen_addr=16'h1E00, char_rom_addr=16'h8000, color_ram_addr=16'h9600, border_color=3, back_color=1, inverted=1, raster=0.
- Write rs=5 din=8'hCC, then rs=2 din=8'h16 -> char_rom_addr=16'h1000, screen_addr=16'h1000, color_ram_addr=16'h9400.
- 301 line_ticks, then read rs=4 and rs=3 -> raster=301 (9'h12D); dout=8'h96, then dout=8'hAE (bit7=1, low bits 2E).
- LINES line_ticks with no frame_tick -> raster wraps 311->0. line_tick with frame_tick at raster=50 -> raster=0.
- Write rs=4 din=8'h55, read rs=4 -> raster[8:1], not 8'h55. Write and read rs=A with 8'hF0 in the same cycle -> dout=old value 8'h00; next read -> 8'hF0.
- Read rs=8 -> 8'hFF; read rs=6 -> 8'h00. Assert reset together with wr rs=F din=8'h00 -> regF=8'h1B.
